// File: rtl/phys_ram_port.sv
// -----------------------------------------------------------------------------
// phys_ram_port
//   Physical-memory responder that sits directly behind the MemoryController
//   physical port. It accepts one read or write request at a time, waits a
//   programmable number of wait states, then completes with a one-cycle
//   phReady pulse. Storage is a byte array addressed with 32-bit
//   little-endian word lanes. Unaligned word accesses are supported.
//
// Parameters
//   ADDR_BITS : byte-address width; memory holds 2^ADDR_BITS bytes (< 32)
//   LATENCY   : wait-state cycles between acceptance and completion (0..15)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   phRamAddress in   [31:0] byte address of the access
//   phRamWrite   in   [31:0] write data, byte 0 = bits [7:0]
//   phReadReq    in   read request, sampled only when idle
//   phWriteReq   in   write request, sampled only when idle
//   phRamRead    out  [31:0] read data, held until the next good read
//   phReady      out  one-cycle completion pulse
//   phBusy       out  high from acceptance through the phReady cycle
//   phFault      out  qualifies phReady (dual request or out-of-range)
// -----------------------------------------------------------------------------
module phys_ram_port #(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] phRamAddress,
   input  logic [31:0] phRamWrite,
   input  logic        phReadReq,
   input  logic        phWriteReq,
   output logic [31:0] phRamRead,
   output logic        phReady,
   output logic        phBusy,
   output logic        phFault
);

   localparam int unsigned MEM_BYTES = 1 << ADDR_BITS;
   // Highest address at which a full 4-byte word still fits in memory.
   localparam logic [31:0] TOP_ADDR  = 32'(MEM_BYTES - 4);
   localparam logic [3:0]  LAT       = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_rd;
   logic        r_wr;
   logic        r_fault;

   logic [7:0]  r_mem [MEM_BYTES];

   logic                 w_req;
   logic                 w_can_accept;
   logic                 w_in_fault;
   logic                 w_enter_done;
   logic [31:0]          w_op_addr;
   logic [31:0]          w_op_data;
   logic                 w_op_rd;
   logic                 w_op_wr;
   logic                 w_op_fault;
   logic                 w_do_write;
   logic                 w_do_read;
   logic [ADDR_BITS-1:0] w_idx [4];
   logic [31:0]          w_rdata;

   assign w_req        = phReadReq | phWriteReq;
   // DONE behaves like IDLE for acceptance so back-to-back requests lose no cycle.
   assign w_can_accept = (r_state != S_WAIT);
   assign w_in_fault   = (phReadReq & phWriteReq) | (phRamAddress > TOP_ADDR);

   // With zero latency the access completes on the acceptance edge itself, so
   // the operation must come straight from the inputs rather than the latches.
   assign w_enter_done = ((r_state == S_WAIT) && (r_cnt == 4'd1)) ||
                         (w_can_accept && w_req && (LAT == 4'd0));

   always_comb begin
      if (w_can_accept) begin
         w_op_addr  = phRamAddress;
         w_op_data  = phRamWrite;
         w_op_rd    = phReadReq;
         w_op_wr    = phWriteReq;
         w_op_fault = w_in_fault;
      end else begin
         w_op_addr  = r_addr;
         w_op_data  = r_wdata;
         w_op_rd    = r_rd;
         w_op_wr    = r_wr;
         w_op_fault = r_fault;
      end
   end

   assign w_do_write = reset & w_enter_done & w_op_wr & ~w_op_fault;
   assign w_do_read  = reset & w_enter_done & w_op_rd & ~w_op_fault;

   // Byte offsets are formed at 32 bits; a non-faulting address never wraps,
   // so truncating to the array index is safe.
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         w_idx[k] = ADDR_BITS'(w_op_addr + 32'(k));
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         w_rdata[8*k +: 8] = r_mem[w_idx[k]];
      end
   end

   // Storage has no reset: contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         for (int unsigned k = 0; k < 4; k++) begin
            r_mem[w_idx[k]] <= w_op_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_fault   <= 1'b0;
         phRamRead <= '0;
         phReady   <= 1'b0;
         phBusy    <= 1'b0;
         phFault   <= 1'b0;
      end else begin
         phReady <= 1'b0;
         phFault <= 1'b0;
         if (w_do_read) begin
            phRamRead <= w_rdata;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               phBusy  <= 1'b0;
               if (w_req) begin
                  r_addr  <= phRamAddress;
                  r_wdata <= phRamWrite;
                  r_rd    <= phReadReq;
                  r_wr    <= phWriteReq;
                  r_fault <= w_in_fault;
                  r_cnt   <= LAT;
                  phBusy  <= 1'b1;
                  if (LAT == 4'd0) begin
                     r_state <= S_DONE;
                     phReady <= 1'b1;
                     phFault <= w_in_fault;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_DONE;
                  phReady <= 1'b1;
                  phFault <= r_fault;
               end
            end
            default: begin
               r_state <= S_IDLE;
               phBusy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phys_ram_port.sv
module tb_phys_ram_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] rdat  [2];
   logic        rdy   [2];
   logic        busy  [2];
   logic        flt   [2];

   int checks = 0;
   int errors = 0;

   // Reference model: known bytes per instance and the last good read value.
   logic [7:0]  m_mem   [2][65536];
   bit          m_valid [2][65536];
   logic [31:0] m_last  [2];

   always #5 clk = ~clk;

   phys_ram_port #(.ADDR_BITS(16), .LATENCY(2)) u_dut2 (
      .clk(clk), .reset(rst_n),
      .phRamAddress(addr[0]), .phRamWrite(wdata[0]),
      .phReadReq(rd[0]), .phWriteReq(wr[0]),
      .phRamRead(rdat[0]), .phReady(rdy[0]), .phBusy(busy[0]), .phFault(flt[0])
   );

   phys_ram_port #(.ADDR_BITS(16), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(rst_n),
      .phRamAddress(addr[1]), .phRamWrite(wdata[1]),
      .phReadReq(rd[1]), .phWriteReq(wr[1]),
      .phRamRead(rdat[1]), .phReady(rdy[1]), .phBusy(busy[1]), .phFault(flt[1])
   );

   function automatic logic [31:0] model_read(input int inst, input logic [31:0] a);
      logic [31:0] v;
      v = 'x;
      for (int k = 0; k < 4; k++) begin
         if (m_valid[inst][int'(a) + k]) v[8*k +: 8] = m_mem[inst][int'(a) + k];
      end
      return v;
   endfunction

   // One complete request on instance inst, checked against the model.
   task automatic do_op(input int inst, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d, input string name);
      int  lat;
      int  cycles;
      bit  exp_fault;
      lat       = (inst == 0) ? 2 : 0;
      exp_fault = (r && w) || (a > 32'h0000_FFFC);
      @(negedge clk);
      addr[inst] = a; wdata[inst] = d; rd[inst] = r; wr[inst] = w;
      @(posedge clk);
      @(negedge clk);
      rd[inst] = 1'b0; wr[inst] = 1'b0;
      cycles = 1;
      while (rdy[inst] !== 1'b1 && cycles < 40) begin
         checks++;
         if (busy[inst] !== 1'b1 || flt[inst] !== 1'b0) begin
            errors++;
            $display("FAIL %s wait-state: busy=%b fault=%b required busy=1 fault=0", name, busy[inst], flt[inst]);
         end
         @(negedge clk);
         cycles++;
      end
      checks++;
      if (rdy[inst] !== 1'b1 || cycles != lat + 1) begin
         errors++;
         $display("FAIL %s latency: ready=%b after %0d cycles, required ready=1 after %0d", name, rdy[inst], cycles, lat + 1);
      end
      checks++;
      if (busy[inst] !== 1'b1 || flt[inst] !== exp_fault) begin
         errors++;
         $display("FAIL %s done flags: busy=%b fault=%b required busy=1 fault=%b", name, busy[inst], flt[inst], exp_fault);
      end
      if (!exp_fault && w) begin
         for (int k = 0; k < 4; k++) begin
            m_mem[inst][int'(a) + k]   = d[8*k +: 8];
            m_valid[inst][int'(a) + k] = 1'b1;
         end
      end
      if (!exp_fault && r) m_last[inst] = model_read(inst, a);
      checks++;
      if (rdat[inst] !== m_last[inst]) begin
         errors++;
         $display("FAIL %s read data: got %h required %h", name, rdat[inst], m_last[inst]);
      end
      @(negedge clk);
      checks++;
      if (rdy[inst] !== 1'b0 || busy[inst] !== 1'b0 || flt[inst] !== 1'b0) begin
         errors++;
         $display("FAIL %s idle after done: ready=%b busy=%b fault=%b required all 0", name, rdy[inst], busy[inst], flt[inst]);
      end
   endtask

   task automatic check_all_zero(input string name);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rdat[i] !== 32'h0 || rdy[i] !== 1'b0 || busy[i] !== 1'b0 || flt[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst%0d: read=%h ready=%b busy=%b fault=%b required all 0",
                     name, i, rdat[i], rdy[i], busy[i], flt[i]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      do_op(0, 0, 1, 32'h0, 32'hDEADBEEF, "wr_deadbeef");
      do_op(0, 1, 0, 32'h0, 32'h0, "rd_deadbeef");
      checks++;
      if (rdat[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_deadbeef_const: got %h required deadbeef", rdat[0]);
      end
   endtask

   task automatic test_unaligned();
      do_op(0, 0, 1, 32'h1, 32'h11223344, "wr_unaligned");
      do_op(0, 1, 0, 32'h0, 32'h0, "rd_unaligned");
      checks++;
      if (rdat[0] !== 32'h223344EF) begin
         errors++;
         $display("FAIL rd_unaligned_const: got %h required 223344ef", rdat[0]);
      end
   endtask

   task automatic test_latency0();
      do_op(1, 0, 1, 32'h4, 32'h89ABCDEF, "lat0_wr");
      do_op(1, 1, 0, 32'h4, 32'h0, "lat0_rd");
      do_op(1, 1, 0, 32'h5, 32'h0, "lat0_rd_unaligned");
      do_op(1, 0, 1, 32'h10000, 32'h1, "lat0_fault");
   endtask

   task automatic test_faults();
      do_op(0, 0, 1, 32'hFFFC, 32'hA5C3_5AA5, "top_word_wr");
      do_op(0, 0, 1, 32'hFFFD, 32'h1234_5678, "wr_fffd_fault");
      do_op(0, 1, 0, 32'hFFFC, 32'h0, "top_word_rd");
      do_op(0, 1, 0, 32'h0001_0000, 32'h0, "rd_10000_fault");
      do_op(0, 1, 0, 32'h8000_0000, 32'h0, "rd_high_bit_fault");
      do_op(0, 1, 1, 32'h0, 32'h0BAD_0BAD, "dual_fault");
      do_op(0, 1, 0, 32'h0, 32'h0, "after_dual_rd");
   endtask

   task automatic test_init_region();
      for (int i = 0; i < 2; i++) begin
         for (int a = 8; a < 68; a += 4) begin
            do_op(i, 0, 1, 32'(a), $urandom, "init_wr");
         end
      end
   endtask

   task automatic test_busy_ignore();
      int          n;
      logic [31:0] exp;
      exp = model_read(0, 32'h8);
      @(negedge clk);
      addr[0] = 32'h8; rd[0] = 1'b1; wr[0] = 1'b0;
      @(posedge clk);
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h5555_5555;
         end
         if (c == 2) wr[0] = 1'b0;
         if (rdy[0] === 1'b1) n++;
      end
      m_last[0] = exp;
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL busy_ignore ready count: got %0d required 1", n);
      end
      checks++;
      if (rdat[0] !== exp) begin
         errors++;
         $display("FAIL busy_ignore read data: got %h required %h", rdat[0], exp);
      end
      do_op(0, 1, 0, 32'h20, 32'h0, "busy_ignore_no_write");
   endtask

   task automatic test_reset_mid();
      do_op(0, 0, 1, 32'h10, 32'h0102_0304, "prefill_10");
      @(negedge clk);
      addr[0] = 32'h10; wdata[0] = 32'hCAFEF00D; wr[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid_wait");
      m_last[0] = 32'h0;
      m_last[1] = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 1, 0, 32'h10, 32'h0, "after_reset_rd");
      do_op(1, 1, 0, 32'h4, 32'h0, "after_reset_lat0_rd");
   endtask

   task automatic test_random();
      int          inst;
      int          kind;
      logic [31:0] a;
      for (int n = 0; n < 160; n++) begin
         inst = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         if (kind < 4) begin
            a = 32'($urandom_range(8, 64));
            do_op(inst, 1, 0, a, 32'h0, "rand_rd");
         end else if (kind < 8) begin
            a = 32'($urandom_range(8, 64));
            do_op(inst, 0, 1, a, $urandom, "rand_wr");
         end else if (kind == 8) begin
            a = 32'hFFFD + 32'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) a = $urandom | 32'h0001_0000;
            do_op(inst, $urandom_range(0, 1) == 1, 1, a, $urandom, "rand_range_fault");
         end else begin
            a = 32'($urandom_range(8, 64));
            do_op(inst, 1, 1, a, $urandom, "rand_dual_fault");
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; wdata[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
         m_last[i] = '0;
      end
      test_reset();
      test_write_read();
      test_unaligned();
      test_latency0();
      test_faults();
      test_init_region();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
